// File: rtl/lcd_feed_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
//   Shared types and constants for the LCD feeder: the 9-bit queued word
//   (RS + data), the power-on init command ROM and the feeder state encoding.
//   Build option: LCD_FEED_INIT_EN (consumed by lcd_feed) selects whether the
//   init ROM is actually used.
// -----------------------------------------------------------------------------
package lcd_pkg;

   // One LCD bus word: rsn=1 marks a command, rsn=0 marks data/address.
   typedef struct packed {
      logic       rsn;
      logic [7:0] data;
   } lcd_word_t;

   localparam int INIT_LEN = 6;
   localparam int IDX_W    = 3;

   // 8->4-bit reset (0x33, 0x32), 2 lines (0x28), display on (0x0C),
   // increment (0x06), clear (0x01). All are sent as commands.
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

   typedef enum logic [1:0] {
      st_pwr  = 2'd0,
      st_init = 2'd1,
      st_gap  = 2'd2,
      st_run  = 2'd3
   } state_t;

endpackage

// File: rtl/lcd_feed_fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
//   DEPTH-word show-ahead synchronous FIFO. The head word is visible on `head`
//   whenever `empty` is low; a pop advances it on the next clock edge.
//   Ports:
//     clk, rstn      clock, synchronous active-low reset (empties the FIFO)
//     push/push_data write request and word
//     pop            remove head word (ignored while empty)
//     head           current head word (undefined while empty)
//     full/empty     occupancy flags
//   A push while full is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module fifo_sync #(
   parameter int W     = 9,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one being freed by the pop.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/lcd_feed.sv
// -----------------------------------------------------------------------------
// lcd_feed
//   Upstream feeder for the 4-bit LCD bus engine. Processor writes are queued
//   in a show-ahead FIFO of {RS, data}. With LCD_FEED_INIT_EN defined, the
//   block first waits PWR_US after reset and then issues the six power-on init
//   commands, each followed by a GAP_US pause, before releasing FIFO traffic.
//   Without the macro, FIFO traffic flows from the first cycle after reset.
//   Ports:
//     clk_i, rstn_i         clock, synchronous active-low reset
//     wr_i, rsn_i, data_i   write strobe and word (accepted in every state)
//     full_o, ovf_o         FIFO full, sticky "write dropped"
//     init_done_o           init finished, FIFO traffic enabled
//     rsn_o, data_o, rd_rdy_o, rd_i  head word read handshake
//     dbg_state_o           current feeder state (lcd_pkg::state_t encoding)
//   Read handshake: rd_rdy_o=1 means {rsn_o,data_o} is a valid word that is
//   held stable until the cycle after rd_i; rd_i consumes it only while
//   rd_rdy_o=1 (otherwise ignored). Outputs read 0 whenever rd_rdy_o=0.
// -----------------------------------------------------------------------------
module lcd_feed
   import lcd_pkg::*;
#(
   parameter real CLK_HZ = 160000000.0,
   parameter int  DEPTH  = 16,
   parameter int  PWR_US = 50000,
   parameter int  GAP_US = 5000
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       wr_i,
   input  logic       rsn_i,
   input  logic [7:0] data_i,
   output logic       full_o,
   output logic       ovf_o,
   output logic       init_done_o,
   output logic       rsn_o,
   output logic [7:0] data_o,
   output logic       rd_rdy_o,
   input  logic       rd_i,
   output logic [1:0] dbg_state_o
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLK_HZ < 1.0e6 || PWR_US < 1 || GAP_US < 1) begin : g_bad_cfg
      $error("lcd_feed: unsupported parameter set");
   end

   state_t    state;
   logic      init_done;
   logic      ovf;
   lcd_word_t wr_word;
   lcd_word_t head_word;
   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_pop;
   logic [7:0] init_data;

   assign wr_word  = {rsn_i, data_i};
   // The FIFO is only drained once the init sequence has handed over.
   assign fifo_pop = rd_i && (state == st_run) && !fifo_empty;

   fifo_sync #(
      .W     ($bits(lcd_word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rstn      (rstn_i),
      .push      (wr_i),
      .push_data (wr_word),
      .pop       (fifo_pop),
      .head      (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         ovf <= 1'b0;
      end else if (wr_i && fifo_full && !fifo_pop) begin
         ovf <= 1'b1;
      end
   end

`ifdef LCD_FEED_INIT_EN
   localparam int PRE_DIV = $rtoi(CLK_HZ / 1.0e6 + 0.5);
   localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam int MAX_US  = (PWR_US > GAP_US) ? PWR_US : GAP_US;
   localparam int UW      = $clog2(MAX_US + 1);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [UW-1:0]    PWR_LAST = UW'(PWR_US - 1);
   localparam logic [UW-1:0]    GAP_LAST = UW'(GAP_US - 1);
   localparam logic [UW-1:0]    US_ONE   = UW'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [PRE_W-1:0] pre_cnt;
   logic [UW-1:0]    us_cnt;
   logic [IDX_W-1:0] idx;
   logic             waiting;
   logic             tick;

   // The prescaler only runs in the wait states and restarts from 0 on
   // entry, so each wait lasts exactly N microseconds of clocks.
   assign waiting   = (state == st_pwr) || (state == st_gap);
   assign tick      = waiting && (pre_cnt == PRE_LAST);
   assign init_data = INIT_ROM[idx];

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state     <= st_pwr;
         idx       <= '0;
         us_cnt    <= '0;
         pre_cnt   <= '0;
         init_done <= 1'b0;
      end else begin
         if (waiting && !tick) pre_cnt <= pre_cnt + PRE_ONE;
         else                  pre_cnt <= '0;

         case (state)
            st_pwr: begin
               if (tick) begin
                  if (us_cnt == PWR_LAST) begin
                     us_cnt <= '0;
                     state  <= st_init;
                  end else begin
                     us_cnt <= us_cnt + US_ONE;
                  end
               end
            end
            st_init: begin
               if (rd_i) state <= st_gap;
            end
            st_gap: begin
               if (tick) begin
                  if (us_cnt == GAP_LAST) begin
                     us_cnt <= '0;
                     if (idx == IDX_LAST) begin
                        state     <= st_run;
                        init_done <= 1'b1;
                     end else begin
                        idx   <= idx + IDX_ONE;
                        state <= st_init;
                     end
                  end else begin
                     us_cnt <= us_cnt + US_ONE;
                  end
               end
            end
            st_run: begin
               init_done <= 1'b1;
            end
            default: begin
               state     <= st_pwr;
               idx       <= '0;
               us_cnt    <= '0;
               init_done <= 1'b0;
            end
         endcase
      end
   end
`else
   assign init_data = 8'h00;

   // No init sequence: the feeder sits in st_run and init_done rises on the
   // first edge after reset is released.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state     <= st_run;
         init_done <= 1'b0;
      end else begin
         state     <= st_run;
         init_done <= 1'b1;
      end
   end
`endif

   always_comb begin
      rd_rdy_o = 1'b0;
      rsn_o    = 1'b0;
      data_o   = 8'h00;
      case (state)
         st_init: begin
            rd_rdy_o = 1'b1;
            rsn_o    = 1'b1;
            data_o   = init_data;
         end
         st_run: begin
            if (!fifo_empty) begin
               rd_rdy_o = 1'b1;
               rsn_o    = head_word.rsn;
               data_o   = head_word.data;
            end
         end
         default: ;
      endcase
   end

   assign full_o      = fifo_full;
   assign ovf_o       = ovf;
   assign init_done_o = init_done;
   assign dbg_state_o = state;

endmodule

// File: tb/tb_lcd_feed.sv
// -----------------------------------------------------------------------------
// tb_lcd_feed
//   Directed bench for lcd_feed with CLK_HZ=10 MHz, DEPTH=4, PWR_US=20,
//   GAP_US=5: 200 clocks of power-up wait and 50 clocks per init gap.
//   The consumer pops 3 clocks after rd_rdy_o. With LCD_FEED_INIT_EN defined
//   the init sequence and reset-abort cases run; otherwise the no-init
//   handover case runs. FIFO full/overflow/simultaneous cases run in both.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_feed;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       wr = 1'b0;
   logic       rsn_in = 1'b0;
   logic [7:0] din = 8'h00;
   logic       rd = 1'b0;
   logic       full;
   logic       ovf;
   logic       init_done;
   logic       rsn_out;
   logic [7:0] dout;
   logic       rd_rdy;
   logic [1:0] dbg_state;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] exp_q[$];
   logic [7:0] init_tab [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

   lcd_feed #(
      .CLK_HZ (10.0e6),
      .DEPTH  (4),
      .PWR_US (20),
      .GAP_US (5)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .wr_i        (wr),
      .rsn_i       (rsn_in),
      .data_i      (din),
      .full_o      (full),
      .ovf_o       (ovf),
      .init_done_o (init_done),
      .rsn_o       (rsn_out),
      .data_o      (dout),
      .rd_rdy_o    (rd_rdy),
      .rd_i        (rd),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #50 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] head_word();
      return {23'd0, rsn_out, dout};
   endfunction

   // ---------------- drivers (entered and left at a negedge) ----------------
   task automatic write_word(input logic rs, input logic [7:0] d, input logic expect_out);
      wr = 1'b1; rsn_in = rs; din = d;
      @(negedge clk);
      wr = 1'b0;
      if (expect_out) exp_q.push_back({rs, d});
   endtask

   task automatic wait_rdy(input string tag, input int budget, output int waited);
      waited = 0;
      while (rd_rdy !== 1'b1 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (rd_rdy !== 1'b1) check_val({tag, " rd_rdy timeout"}, 32'(rd_rdy), 1);
   endtask

   // Consumer: sees rd_rdy, waits 3 clocks, checks the head and pops it.
   task automatic consume(input string tag, input int budget, output int waited);
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] e;
      wait_rdy(tag, budget, waited);
      if (rd_rdy !== 1'b1) return;
      w0 = head_word();
      repeat (3) @(negedge clk);
      w1 = head_word();
      if (exp_q.size() == 0) begin
         check_val({tag, " unexpected word"}, w1, 32'hFFFF_FFFF);
      end else begin
         e = 32'(exp_q.pop_front());
         check_val({tag, " head"}, w0, e);
         check_val({tag, " held"}, w1, e);
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic push_init_exp();
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, init_tab[i]});
   endtask

   // Consume the five init words after the first, checking each 50-clock gap.
   task automatic consume_init_rest(input string tag);
      int w;
      for (int i = 1; i < 6; i++) begin
         consume($sformatf("%s init%0d", tag, i), 200, w);
         check_val($sformatf("%s gap%0d", tag, i), 32'(w >= 50 && w <= 51), 1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;

      // Reset values
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst rd_rdy", 32'(rd_rdy), 0);
      check_val("rst full", 32'(full), 0);
      check_val("rst ovf", 32'(ovf), 0);
      check_val("rst init_done", 32'(init_done), 0);
      check_val("rst word", head_word(), 0);
      rstn = 1'b1;

`ifdef LCD_FEED_INIT_EN
      // 1/2: power-up wait, init words, then the two words written during st_pwr
      push_init_exp();
      write_word(1'b0, 8'h41, 1'b1);
      write_word(1'b1, 8'h80, 1'b1);
      check_val("t2 state pwr", 32'(dbg_state), 32'(st_pwr));
      consume("t1 init0", 400, w);
      check_val("t1 pwr wait", 32'(w + 2 >= 200 && w + 2 <= 201), 1);
      check_val("t1 init_done low", 32'(init_done), 0);
      consume_init_rest("t1");
      wait_rdy("t2 first", 200, w);
      check_val("t2 init_done before data", 32'(init_done), 1);
      check_val("t2 last gap", 32'(w >= 50 && w <= 51), 1);
      consume("t2 w41", 10, w);
      consume("t2 w80", 10, w);
      check_val("t2 drained", 32'(rd_rdy), 0);
`else
      // 6: no init sequence
      @(negedge clk);
      check_val("t6 init_done", 32'(init_done), 1);
      check_val("t6 state run", 32'(dbg_state), 32'(st_run));
      write_word(1'b0, 8'h01, 1'b1);
      check_val("t6 rd_rdy next cycle", 32'(rd_rdy), 1);
      check_val("t6 word", head_word(), 32'h001);
      consume("t6 w01", 5, w);
      check_val("t6 drained", 32'(rd_rdy), 0);
`endif

      // 3: fill, overflow, drain
      check_val("t3 ovf clear", 32'(ovf), 0);
      write_word(1'b0, 8'hA1, 1'b1);
      write_word(1'b1, 8'hB2, 1'b1);
      write_word(1'b0, 8'hC3, 1'b1);
      check_val("t3 not full at 3", 32'(full), 0);
      write_word(1'b1, 8'hD4, 1'b1);
      check_val("t3 full at 4", 32'(full), 1);
      check_val("t3 ovf before drop", 32'(ovf), 0);
      write_word(1'b0, 8'hE5, 1'b0);
      check_val("t3 ovf after drop", 32'(ovf), 1);
      check_val("t3 still full", 32'(full), 1);
      for (int i = 0; i < 4; i++) consume($sformatf("t3 w%0d", i), 10, w);
      check_val("t3 ovf sticky", 32'(ovf), 1);
      check_val("t3 drained", 32'(rd_rdy), 0);
      check_val("t3 not full", 32'(full), 0);

      // 4: full + write&pop, then empty + write&pop
      write_word(1'b0, 8'h11, 1'b1);
      write_word(1'b0, 8'h22, 1'b1);
      write_word(1'b1, 8'h33, 1'b1);
      write_word(1'b0, 8'h44, 1'b1);
      check_val("t4 full", 32'(full), 1);
      check_val("t4 head before", head_word(), 32'(exp_q[0]));
      wr = 1'b1; rd = 1'b1; rsn_in = 1'b1; din = 8'h5A;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back({1'b1, 8'h5A});
      check_val("t4 full kept", 32'(full), 1);
      for (int i = 0; i < 4; i++) consume($sformatf("t4 w%0d", i), 10, w);
      check_val("t4 drained", 32'(rd_rdy), 0);
      wr = 1'b1; rd = 1'b1; rsn_in = 1'b0; din = 8'h55;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      check_val("t4 empty wr&rd rdy", 32'(rd_rdy), 1);
      check_val("t4 empty wr&rd word", head_word(), 32'h055);
      exp_q.push_back({1'b0, 8'h55});
      consume("t4 w55", 5, w);
      check_val("t4 end drained", 32'(rd_rdy), 0);

`ifdef LCD_FEED_INIT_EN
      // 5: reset during the gap after 0x28 restarts the sequence
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      push_init_exp();
      write_word(1'b0, 8'h99, 1'b0);
      for (int i = 0; i < 3; i++) consume($sformatf("t5 pre%0d", i), 400, w);
      repeat (10) @(negedge clk);
      check_val("t5 in gap", 32'(dbg_state), 32'(st_gap));
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check_val("t5 rst rd_rdy", 32'(rd_rdy), 0);
      check_val("t5 rst init_done", 32'(init_done), 0);
      exp_q.delete();
      push_init_exp();
      consume("t5 init0", 400, w);
      check_val("t5 pwr wait", 32'(w >= 200 && w <= 201), 1);
      consume_init_rest("t5");
      repeat (60) @(negedge clk);
      check_val("t5 init_done", 32'(init_done), 1);
      check_val("t5 fifo emptied", 32'(rd_rdy), 0);
`endif

      check_val("scoreboard empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
